// File: rtl/simd_regfile_sb_if.sv
// Bus between decode/issue + writeback and the SIMD register file with scoreboard.
// master = issue/writeback side, slave = register file.
interface simd_regfile_sb_if #(
    parameter int AW     = 4,
    parameter int LANES  = 4,
    parameter int LANE_W = 16
);
    localparam int DW = LANES * LANE_W;

    // init/clear sweep control
    logic              clr_req;
    logic              ready;
    // read ports
    logic [AW-1:0]     rs1_addr;
    logic [DW-1:0]     rs1_data;
    logic [AW-1:0]     rs2_addr;
    logic [DW-1:0]     rs2_data;
    logic              rs1_busy;
    logic              rs2_busy;
    // writeback port
    logic              we;
    logic [AW-1:0]     rd_addr;
    logic [LANES-1:0]  we_mask;
    logic [DW-1:0]     rd_data;
    // issue reservation
    logic              rsv_valid;
    logic [AW-1:0]     rsv_addr;
    logic              rsv_busy;
    logic              sb_err;

    modport master (
        output clr_req, rs1_addr, rs2_addr, we, rd_addr, we_mask, rd_data,
               rsv_valid, rsv_addr,
        input  ready, rs1_data, rs2_data, rs1_busy, rs2_busy, rsv_busy, sb_err
    );

    modport slave (
        input  clr_req, rs1_addr, rs2_addr, we, rd_addr, we_mask, rd_data,
               rsv_valid, rsv_addr,
        output ready, rs1_data, rs2_data, rs1_busy, rs2_busy, rsv_busy, sb_err
    );
endinterface

// File: rtl/simd_regfile_sb.sv
// SIMD register file: NUM_REGS x (LANES x LANE_W), 2 async read ports,
// 1 sync lane-masked write port, per-register issue scoreboard and a
// sequential init sweep (TID_REG gets packed thread IDs, all others 0).
// The array has no reset so it can map to LUT-RAM.
// Optional macro RF_BYPASS_EN: same-cycle write-to-read bypass on masked lanes.
module simd_regfile_sb #(
    parameter int NUM_REGS    = 16,
    parameter int LANES       = 4,
    parameter int LANE_W      = 16,
    parameter int THREAD_BASE = 0,
    parameter int TID_REG     = 14,
    parameter int ZERO_REG    = 15
) (
    input  logic               clk,
    input  logic               rst,
    simd_regfile_sb_if.slave   bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int DW = LANES * LANE_W;
    localparam logic [AW-1:0] TID_A  = AW'(TID_REG);
    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);
    localparam logic [AW-1:0] LAST_A = AW'(NUM_REGS - 1);

    typedef enum logic {SWEEP, RUN} state_t;

    state_t                state_q;
    logic [AW-1:0]         idx_q;
    logic                  ready_q;
    logic                  sb_err_q;
    logic                  sb_err_d;
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;
    logic [DW-1:0]         mem_q [NUM_REGS];
    logic [DW-1:0]         tid_init;
    logic [DW-1:0]         wr_merged;
    logic [DW-1:0]         rs1_val;
    logic [DW-1:0]         rs2_val;

    // Packed thread IDs: lane k = THREAD_BASE + k, lane 0 in the LSBs
    always_comb begin
        tid_init = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            tid_init[k*LANE_W +: LANE_W] = LANE_W'(THREAD_BASE + k);
        end
    end

    // Merge masked writeback lanes over the currently stored word
    always_comb begin
        wr_merged = mem_q[bus.rd_addr];
        for (int unsigned k = 0; k < LANES; k++) begin
            if (bus.we_mask[k]) begin
                wr_merged[k*LANE_W +: LANE_W] = bus.rd_data[k*LANE_W +: LANE_W];
            end
        end
    end

    // Scoreboard next state: reserve beats release on the same register
    always_comb begin
        busy_d   = busy_q;
        sb_err_d = sb_err_q;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (bus.rsv_valid && bus.rsv_addr == AW'(r) && AW'(r) != ZERO_A) begin
                busy_d[r] = 1'b1;
            end else if (bus.we && bus.rd_addr == AW'(r)) begin
                busy_d[r] = 1'b0;
            end
        end
        if (bus.rsv_valid && busy_q[bus.rsv_addr] &&
            !(bus.we && bus.rd_addr == bus.rsv_addr)) begin
            sb_err_d = 1'b1;
        end
    end

    // Control FSM: sweep sequencing, ready, scoreboard and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SWEEP;
            idx_q    <= '0;
            busy_q   <= '0;
            sb_err_q <= 1'b0;
            ready_q  <= 1'b0;
        end else if (bus.clr_req) begin
            state_q  <= SWEEP;
            idx_q    <= '0;
            busy_q   <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                SWEEP: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST_A) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    busy_q   <= busy_d;
                    sb_err_q <= sb_err_d;
                end
                default: state_q <= SWEEP;
            endcase
        end
    end

    // Single array write port: sweep init in SWEEP, masked writeback in RUN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == SWEEP) begin
                mem_q[idx_q] <= (idx_q == TID_A) ? tid_init : '0;
            end else if (bus.we && bus.rd_addr != ZERO_A) begin
                mem_q[bus.rd_addr] <= wr_merged;
            end
        end
    end

    // Async reads: zero in SWEEP and for ZERO_REG
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (state_q == RUN) begin
            if (bus.rs1_addr != ZERO_A) rs1_val = mem_q[bus.rs1_addr];
            if (bus.rs2_addr != ZERO_A) rs2_val = mem_q[bus.rs2_addr];
`ifdef RF_BYPASS_EN
            for (int unsigned k = 0; k < LANES; k++) begin
                if (bus.we && bus.we_mask[k] && bus.rd_addr != ZERO_A) begin
                    if (bus.rs1_addr == bus.rd_addr)
                        rs1_val[k*LANE_W +: LANE_W] = bus.rd_data[k*LANE_W +: LANE_W];
                    if (bus.rs2_addr == bus.rd_addr)
                        rs2_val[k*LANE_W +: LANE_W] = bus.rd_data[k*LANE_W +: LANE_W];
                end
            end
`endif
        end
    end

    // busy_q is forced clear throughout SWEEP, so no extra gating is needed
    assign bus.rs1_data = rs1_val;
    assign bus.rs2_data = rs2_val;
    assign bus.rs1_busy = busy_q[bus.rs1_addr];
    assign bus.rs2_busy = busy_q[bus.rs2_addr];
    assign bus.rsv_busy = busy_q[bus.rsv_addr];
    assign bus.ready    = ready_q;
    assign bus.sb_err   = sb_err_q;

endmodule
